// File: rtl/dnn_infer_ctrl_pkg.sv
// dnn_infer_ctrl shared types and constants.
// States, class count and error digit for the inference sequencer.
package dnn_ctrl_pkg;

  localparam int         N_CLASSES_C = 10;
  localparam logic [3:0] ERR_DIGIT_C = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    ARGMAX,
    RESULT
  } ctrl_state_t;

endpackage

// File: rtl/dnn_infer_ctrl_if.sv
// dnn_infer_ctrl host-side bundle.
// Pixel stream in, classified digit out.
interface dnn_infer_ctrl_if #(
  parameter int DATA_WIDTH = 12
);
  logic                         pix_valid;
  logic                         pix_ready;
  logic        [DATA_WIDTH-1:0] pix_data;
  logic                         res_valid;
  logic                         res_ready;
  logic        [3:0]            res_digit;
  logic signed [DATA_WIDTH-1:0] res_score;
  logic                         res_err;

  modport master (
    output pix_valid, pix_data, res_ready,
    input  pix_ready, res_valid, res_digit,
    input  res_score, res_err
  );

  modport slave (
    input  pix_valid, pix_data, res_ready,
    output pix_ready, res_valid, res_digit,
    output res_score, res_err
  );
endinterface

// File: rtl/dnn_infer_ctrl_argmax.sv
// dnn_argmax_seq: one class per cycle argmax.
// Strict signed greater-than, so ties keep the lowest index.
module dnn_argmax_seq #(
  parameter int DATA_WIDTH = 12,
  parameter int N_CLASSES  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] vals [N_CLASSES],
  output logic                         done,
  output logic        [3:0]            idx,
  output logic signed [DATA_WIDTH-1:0] val
);
  logic [3:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic [3:0] idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] val_q, val_d;
  logic signed [DATA_WIDTH-1:0] cur;

  // scan index and running best
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    idx_d = idx_q;
    val_d = val_q;
    cur   = vals[cnt_q];
    done  = run_q && (cnt_q == 4'(N_CLASSES - 1));
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
    end else if (run_q) begin
      if ((cnt_q == '0) || (cur > val_q)) begin
        idx_d = cnt_q;
        val_d = cur;
      end
      if (done) run_d = 1'b0;
      else      cnt_d = cnt_q + 4'd1;
    end
  end

  // scan state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      idx_q <= '0;
      val_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end

  assign idx = idx_q;
  assign val = val_q;
endmodule

// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: pixel loader, engine sequencer, argmax result.
// Optional RUN watchdog: DNN_INFER_CTRL_TIMEOUT_EN.
module dnn_infer_ctrl #(
  parameter int              DATA_WIDTH     = 12,
  parameter int              ADDR_WIDTH     = 16,
  parameter [ADDR_WIDTH-1:0] ADDR_BASE_A    = '0,
  parameter int              IMG_WORDS      = 400,
  parameter int              N_CLASSES      = dnn_ctrl_pkg::N_CLASSES_C,
  parameter int              TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  dnn_infer_ctrl_if.slave              io,
  output logic                         mem_we,
  output logic        [DATA_WIDTH-1:0] mem_wdata,
  output logic        [ADDR_WIDTH-1:0] mem_addr,
  input  logic        [ADDR_WIDTH-1:0] dnn_mem_addr,
  output logic                         dnn_start,
  output logic                         dnn_reset,
  input  logic                         dnn_done,
  input  logic signed [DATA_WIDTH-1:0] dnn_out [N_CLASSES],
  output logic                         busy
);
  import dnn_ctrl_pkg::*;

  localparam int CW = $clog2(IMG_WORDS + 1);

  ctrl_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ldr_q, ldr_d, ldr_addr;
  logic alive_q;
  logic signed [DATA_WIDTH-1:0] cap_q [N_CLASSES];
  logic signed [DATA_WIDTH-1:0] cap_d [N_CLASSES];
  logic accept, eng_on, res_on;
  logic am_start, am_done;
  logic [3:0] am_idx;
  logic signed [DATA_WIDTH-1:0] am_val;
  logic err;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // loader port, address mux and result payload
  always_comb begin
    eng_on = (state_q == START) || (state_q == RUN) ||
             (state_q == ARGMAX);
    res_on = (state_q == RESULT);
    io.pix_ready = alive_q &&
                   ((state_q == IDLE) || (state_q == LOAD));
    accept    = io.pix_valid && io.pix_ready;
    ldr_addr  = ADDR_BASE_A + ADDR_WIDTH'(cnt_q);
    ldr_d     = accept ? ldr_addr : ldr_q;
    mem_we    = accept;
    mem_wdata = accept ? io.pix_data : '0;
    if (eng_on)      mem_addr = dnn_mem_addr;
    else if (accept) mem_addr = ldr_addr;
    else             mem_addr = ldr_q;
    dnn_reset = accept && (state_q == IDLE);
    dnn_start = (state_q == START);
    busy      = (state_q != IDLE);
    io.res_valid = res_on;
    io.res_err   = res_on && err;
    io.res_digit = '0;
    io.res_score = '0;
    if (res_on) begin
      io.res_digit = err ? ERR_DIGIT_C : am_idx;
      io.res_score = err ? '0 : am_val;
    end
  end

  // sequencer next state, pixel count, output capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    am_start = 1'b0;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
    wd_d  = '0;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: if (accept) begin
        if (IMG_WORDS == 1) begin
          state_d = START;
        end else begin
          state_d = LOAD;
          cnt_d   = CW'(1);
        end
      end
      LOAD: if (accept) begin
        if (cnt_q == CW'(IMG_WORDS - 1)) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      START: state_d = RUN;
      RUN: begin
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
        wd_d = wd_q + 32'd1;
`endif
        if (dnn_done) begin
          cap_d    = dnn_out;
          am_start = 1'b1;
          state_d  = ARGMAX;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
          err_d = 1'b0;
        end else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESULT;
`endif
        end
      end
      ARGMAX: if (am_done) state_d = RESULT;
      RESULT: if (io.res_ready) begin
        state_d = IDLE;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // sequencer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ldr_q   <= '0;
      alive_q <= 1'b0;
      for (int i = 0; i < N_CLASSES; i++) cap_q[i] <= '0;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
      wd_q  <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldr_q   <= ldr_d;
      alive_q <= 1'b1;
      cap_q   <= cap_d;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
      wd_q  <= wd_d;
      err_q <= err_d;
`endif
    end
  end

  dnn_argmax_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_CLASSES  (N_CLASSES)
  ) u_argmax (
    .clk   (clk),
    .rst   (rst),
    .start (am_start),
    .vals  (cap_q),
    .done  (am_done),
    .idx   (am_idx),
    .val   (am_val)
  );
endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// tb_dnn_infer_ctrl: directed bench for dnn_infer_ctrl.
// Covers load, argmax ties, backpressure, mid-load reset, watchdog.
module tb_dnn_infer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_we;
  logic [11:0] mem_wdata;
  logic [15:0] mem_addr;
  logic [15:0] dnn_mem_addr = 16'h03A5;
  logic dnn_start, dnn_reset, busy;
  logic dnn_done = 1'b0;
  logic signed [11:0] dnn_out [10];

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int n_drst = 0;
  bit in_run = 1'b0;
  int w0, d0, k;

  dnn_infer_ctrl_if #(.DATA_WIDTH(12)) bus();

  dnn_infer_ctrl #(
    .DATA_WIDTH     (12),
    .ADDR_WIDTH     (16),
    .ADDR_BASE_A    (16'h0000),
    .IMG_WORDS      (400),
    .N_CLASSES      (10),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (bus.slave),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_addr     (mem_addr),
    .dnn_mem_addr (dnn_mem_addr),
    .dnn_start    (dnn_start),
    .dnn_reset    (dnn_reset),
    .dnn_done     (dnn_done),
    .dnn_out      (dnn_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_outs(input int v [10]);
    for (int i = 0; i < 10; i++) dnn_out[i] = 12'(v[i]);
  endtask

  task automatic send_image(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        while ($urandom_range(1, 0) == 1) begin
          bus.pix_valid = 1'b0;
          tick();
        end
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = 12'(i);
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  // called in the START cycle
  task automatic run_engine(int dly, int e_dig, int e_sc);
    chk("start", dnn_start, 1);
    bus.pix_valid = 1'b1;
    repeat (dly) tick();
    chk("start_once", dnn_start, 0);
    dnn_done = 1'b1;
    tick();
    dnn_done = 1'b0;
    bus.pix_valid = 1'b0;
    set_outs('{100, 100, 100, 100, 100, 100, 100, 100, 100, 100});
    k = 1;
    while (!bus.res_valid && k < 40) begin
      tick();
      k++;
    end
    chk("latency", k, 11);
    chk("digit", bus.res_digit, e_dig);
    chk("score", bus.res_score, e_sc);
    chk("err", bus.res_err, 0);
  endtask

  // write stream and RUN-phase isolation monitor
  always @(negedge clk) begin
    if (!rst) begin
      wr_cnt = 0;
      in_run = 1'b0;
    end else begin
      if (dnn_reset) begin
        n_drst++;
        chk("drst_we", mem_we, 1);
        chk("drst_pos", wr_cnt % 400, 0);
      end
      if (mem_we) begin
        chk("waddr", mem_addr, wr_cnt % 400);
        chk("wdata", mem_wdata, wr_cnt % 400);
        wr_cnt++;
      end
      if (bus.res_valid) begin
        in_run = 1'b0;
      end else if (in_run || dnn_start) begin
        chk("run_we", mem_we, 0);
        chk("run_rdy", bus.pix_ready, 0);
        chk("run_addr", mem_addr, dnn_mem_addr);
        in_run = !dnn_done;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.res_ready = 1'b0;
    set_outs('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #2;
    chk("rst_rdy", bus.pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_start", dnn_start, 0);
    chk("rst_valid", bus.res_valid, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rel_rdy0", bus.pix_ready, 0);
    tick();
    chk("rel_rdy1", bus.pix_ready, 1);
    chk("idle_addr", mem_addr, 0);
    dnn_done = 1'b1;
    tick();
    dnn_done = 1'b0;
    chk("done_ign", busy, 0);

    // image 1: straight stream, tie resolves low
    w0 = wr_cnt;
    d0 = n_drst;
    send_image(400, 1'b0);
    chk("nwr1", wr_cnt - w0, 400);
    chk("ndrst1", n_drst - d0, 1);
    set_outs('{-5, 3, 7, 2, 7, 1, 0, -1, 6, 4});
    run_engine(50, 2, 7);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_v", bus.res_valid, 1);
      chk("hold_d", bus.res_digit, 2);
      chk("hold_s", bus.res_score, 7);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("ret_busy", busy, 0);
    chk("ret_valid", bus.res_valid, 0);
    chk("ret_addr", mem_addr, 399);

    // image 2: random valid, all negative, ready early
    w0 = wr_cnt;
    d0 = n_drst;
    send_image(400, 1'b1);
    chk("nwr2", wr_cnt - w0, 400);
    chk("ndrst2", n_drst - d0, 1);
    set_outs('{-9, -3, -3, -20, -100, -4, -5, -3, -2048, -7});
    run_engine(5, 1, -3);
    tick();
    chk("pulse_v", bus.res_valid, 0);
    chk("pulse_busy", busy, 0);
    bus.res_ready = 1'b0;

    // image 3: reset mid-load then full image
    send_image(200, 1'b0);
    bus.pix_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("mr_we", mem_we, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_data", mem_wdata, 0);
    chk("mr_rdy", bus.pix_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_drst", dnn_reset, 0);
    chk("mr_start", dnn_start, 0);
    tick();
    #2 rst = 1'b1;
    bus.pix_valid = 1'b0;
    tick();
    chk("mr_rdy1", bus.pix_ready, 1);
    w0 = wr_cnt;
    d0 = n_drst;
    send_image(400, 1'b1);
    chk("nwr3", wr_cnt - w0, 400);
    chk("ndrst3", n_drst - d0, 1);
    set_outs('{1, 2, 3, 4, 5, 6, 7, 8, 9, 500});
    run_engine(20, 9, 500);
    bus.res_ready = 1'b1;
    tick();
    chk("ret3", busy, 0);

    // image 4: all equal keeps index 0
    send_image(400, 1'b0);
    set_outs('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7});
    run_engine(3, 0, 7);
    tick();
    chk("ret4", busy, 0);
    bus.res_ready = 1'b0;

`ifdef DNN_INFER_CTRL_TIMEOUT_EN
    // image 5: engine never finishes
    send_image(400, 1'b0);
    chk("to_start", dnn_start, 1);
    k = 0;
    while (!bus.res_valid && k < 300) begin
      tick();
      k++;
    end
    chk("to_lat", k, 101);
    chk("to_err", bus.res_err, 1);
    chk("to_digit", bus.res_digit, 15);
    chk("to_score", bus.res_score, 0);
    bus.res_ready = 1'b1;
    tick();
    chk("to_ret", busy, 0);
    chk("to_errclr", bus.res_err, 0);
    bus.res_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dnn_infer_ctrl.md
# dnn_infer_ctrl

Inference sequencer for the fixed-point sigmoid MNIST engine. It accepts an image as a pixel stream and writes it into the shared activation memory. It then resets and starts the engine, waits for `done`, and computes a sequential argmax over the 10 class outputs. The classified digit is returned on a valid/ready result port. It sits between the host/stream side and the engine, and owns the activation-memory write port and the memory address mux.

## Interface
- `DATA_WIDTH`, 12, fixed-point word width (pixels, engine outputs, score)
- `ADDR_WIDTH`, 16, memory address width
- `ADDR_BASE_A`, 16'h0000, first activation address for pixel writes
- `IMG_WORDS`, 400, pixels per image
- `N_CLASSES`, 10, engine output count
- `TIMEOUT_CYCLES`, 65535, watchdog limit (used only with the macro)
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous, active-low
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in DATA_WIDTH: pixel stream
- `mem_we` out 1, `mem_wdata` out DATA_WIDTH, `mem_addr` out ADDR_WIDTH: shared memory port
- `dnn_mem_addr` in ADDR_WIDTH: engine read address, muxed onto `mem_addr`
- `dnn_start` out 1, `dnn_reset` out 1: engine control pulses
- `dnn_done` in 1: engine completion
- `dnn_out` in signed DATA_WIDTH [N_CLASSES-1:0]: engine outputs
- `res_valid` out 1, `res_ready` in 1: result handshake
- `res_digit` out 4, `res_score` out signed DATA_WIDTH, `res_err` out 1: result payload
- `busy` out 1: high in every state except IDLE

## Operation
- States and transitions:
  - IDLE → LOAD on the first accepted pixel.
  - LOAD → START on acceptance of pixel IMG_WORDS-1.
  - START → RUN after 1 cycle.
  - RUN → ARGMAX when `dnn_done`=1.
  - ARGMAX → RESULT after N_CLASSES cycles.
  - RESULT → IDLE on `res_valid`&&`res_ready`.
- `pix_ready`=1 only in IDLE and LOAD.
- Each accepted pixel is written combinationally in the same cycle:
  - `mem_we`=1, `mem_wdata`=`pix_data`, `mem_addr`=ADDR_BASE_A+pix_cnt.
  - pix_cnt runs 0..IMG_WORDS-1 and clears on leaving LOAD.
- `dnn_reset` pulses for 1 cycle on the IDLE→LOAD acceptance cycle.
- `dnn_start` is high for exactly the 1 cycle spent in START.
- Address mux:
  - `mem_addr`=`dnn_mem_addr` in START, RUN and ARGMAX.
  - In every other state `mem_addr` is the loader address (held at last value when not writing).
- `mem_we`=0 outside accepted-pixel cycles.
- In RUN, the cycle `dnn_done`=1 captures all `dnn_out` into an internal register array. The argmax reads only this array.
- Argmax rules:
  - Signed compare, strict greater-than, index 0 first, so a tie keeps the lowest index.
  - Result is best index and best value.
- RESULT holds `res_digit`, `res_score` and `res_valid`=1 stable until the handshake.

## Timing
- Reset value of all outputs is 0, including `pix_ready`=0 during reset.
- One cycle after reset release: state IDLE with `pix_ready`=1.
- Load phase: minimum IMG_WORDS cycles. Back-pressure is only from `pix_valid`.
- Latency from the `dnn_done` cycle to `res_valid`=1: N_CLASSES+1 cycles.
- `dnn_done` outside RUN is ignored.
- `pix_valid` outside IDLE/LOAD is ignored and nothing is written.
- `res_ready` without `res_valid` is ignored.
- If `res_ready` is already high when RESULT is entered, `res_valid` lasts exactly 1 cycle.
- Reset mid-operation:
  - Asynchronous return to IDLE; all counters and outputs cleared; the partial image is abandoned.
  - The next image re-pulses `dnn_reset`.

## Configuration
- Macro: `DNN_INFER_CTRL_TIMEOUT_EN`.
- Defined:
  - A watchdog counts RUN cycles.
  - On reaching TIMEOUT_CYCLES without `dnn_done`, go to RESULT with `res_err`=1, `res_digit`=4'hF, `res_score`=0.
  - `dnn_done` arriving on the same cycle as the limit takes precedence, giving a normal result.
- Undefined: no counter; RUN waits indefinitely; `res_err` is tied to 0.

## Structure
- Package `dnn_ctrl_pkg` holds:
  - the state enum `ctrl_state_t` (IDLE, LOAD, START, RUN, ARGMAX, RESULT)
  - `N_CLASSES_C`=10
  - `ERR_DIGIT_C`=4'hF
- Sub-module `dnn_argmax_seq`:
  - Interface: start pulse, captured array, index counter, running best.
  - Outputs: `done`, `idx`, `val`.
  - N_CLASSES cycles per run.
- The top level contains the FSM, the pixel counter, the address mux and the watchdog.

## Test plan
- Stream pixels 0..399 with `pix_valid` held high:
  - 400 writes at addresses 0x0000..0x018F, data equal to the index.
  - `dnn_reset` pulses once on the first write; `dnn_start` pulses 1 cycle after the last write.
- Model `dnn_done` 50 cycles after start with outputs {-5,3,7,2,7,…}:
  - `res_digit`=2, `res_score`=7 (tie resolves to the lower index).
  - `res_valid` 11 cycles after `dnn_done`.
- Hold `res_ready`=0 for 20 cycles:
  - Payload stable throughout; returns to IDLE 1 cycle after `res_ready`=1.
- Toggle `pix_valid` randomly, and assert `pix_valid` during RUN:
  - Exactly 400 writes; no write and `pix_ready`=0 while in RUN.
- Assert `rst`=0 at pixel 200:
  - All outputs 0 immediately; the next image restarts at address 0x0000 with a fresh `dnn_reset` pulse.
- With `DNN_INFER_CTRL_TIMEOUT_EN` defined, TIMEOUT_CYCLES=100 and `dnn_done` never asserted:
  - `res_err`=1, `res_digit`=4'hF after 100 RUN cycles.
